// File: rtl/bram_sdp.sv
// ---------------------------------------------------------------------------
// bram_sdp -- simple dual-port block RAM with byte-lane writes, optional output
// register, selectable read/write collision behaviour and a built-in clear
// sweep that fills every word with a programmable value.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset (memory contents are kept)
//   wr_en      : write request (dropped while busy)
//   wr_be      : per-lane write enable, lane k = bits [k*BYTE_W +: BYTE_W]
//   wr_addr    : write address
//   wr_data    : write data
//   rd_en      : read request (accepted every cycle, also while busy)
//   rd_addr    : read address
//   rd_data    : read data, held between completed reads
//   rd_valid   : one-cycle pulse qualifying rd_data
//   clr_req    : single-cycle request to start a clear sweep
//   clr_data   : fill value, captured when the sweep starts
//   busy       : high while the clear sweep runs
//   clr_done   : one-cycle pulse when the sweep has written the last word
// ---------------------------------------------------------------------------
module bram_sdp #(
    parameter int DATA_W     = 16,
    parameter int BYTE_W     = 8,
    parameter int ADDR_W     = 11,
    parameter int OUT_REG    = 0,
    parameter int WR_FIRST   = 0,
    parameter int AUTO_CLEAR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W/BYTE_W-1:0]   wr_be,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       clr_req,
    input  logic [DATA_W-1:0]          clr_data,
    output logic                       busy,
    output logic                       clr_done
);

    localparam int NBE   = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Storage: no reset so the array maps onto block RAM.
    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q,      state_d;
    logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;
    logic [DATA_W-1:0] clr_val_q,    clr_val_d;
    logic              auto_pend_q,  auto_pend_d;
    logic              busy_q,       busy_d;
    logic              clr_done_q,   clr_done_d;
    logic [DATA_W-1:0] rd1_data_q,   rd1_data_d;
    logic              rd1_valid_q,  rd1_valid_d;

    // Unified write port shared by user writes and the sweep.
    logic [NBE-1:0]    mem_lane_we_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] rd_word_s;

    // Clear-sweep FSM next state, sweep address and completion pulse.
    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        clr_val_d    = clr_val_q;
        clr_done_d   = 1'b0;
        // The auto-clear request only survives the first edge after reset.
        auto_pend_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (auto_pend_q) begin
                    state_d      = ST_CLEAR;
                    clr_val_d    = {DATA_W{1'b0}};
                    sweep_addr_d = {ADDR_W{1'b0}};
                end else if (clr_req) begin
                    state_d      = ST_CLEAR;
                    clr_val_d    = clr_data;
                    sweep_addr_d = {ADDR_W{1'b0}};
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // clr_req is deliberately not looked at here: no restart, no queueing.
                sweep_addr_d = sweep_addr_q + ADDR_W'(1'b1);
                if (sweep_addr_q == {ADDR_W{1'b1}}) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    state_d    = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Write-port arbitration: the sweep owns the port, user writes are dropped.
    always_comb begin
        mem_lane_we_s = {NBE{1'b0}};
        mem_waddr_s   = wr_addr;
        mem_wdata_s   = wr_data;
        if (state_q == ST_CLEAR) begin
            mem_lane_we_s = {NBE{1'b1}};
            mem_waddr_s   = sweep_addr_q;
            mem_wdata_s   = clr_val_q;
        end else if (wr_en) begin
            mem_lane_we_s = wr_be;
        end else begin
            mem_lane_we_s = {NBE{1'b0}};
        end
        mem_we_s = |mem_lane_we_s;
    end

    // Byte-lane memory write.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NBE; k++) begin
            if (mem_lane_we_s[k]) begin
                mem_q[mem_waddr_s][k*BYTE_W +: BYTE_W] <= mem_wdata_s[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Read word selection; in write-first mode a colliding write is merged per lane.
    always_comb begin
        rd_word_s = mem_q[rd_addr];
        if ((WR_FIRST != 0) && mem_we_s && (mem_waddr_s == rd_addr)) begin
            for (int k = 0; k < NBE; k++) begin
                rd_word_s[k*BYTE_W +: BYTE_W] = mem_lane_we_s[k] ?
                    mem_wdata_s[k*BYTE_W +: BYTE_W] : mem_q[rd_addr][k*BYTE_W +: BYTE_W];
            end
        end else begin
            rd_word_s = mem_q[rd_addr];
        end
    end

    // First read stage: capture on rd_en, otherwise hold.
    always_comb begin
        if (rd_en) begin
            rd1_data_d = rd_word_s;
        end else begin
            rd1_data_d = rd1_data_q;
        end
        rd1_valid_d = rd_en;
    end

    // Control and first read stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sweep_addr_q <= {ADDR_W{1'b0}};
            clr_val_q    <= {DATA_W{1'b0}};
            auto_pend_q  <= (AUTO_CLEAR != 0);
            busy_q       <= 1'b0;
            clr_done_q   <= 1'b0;
            rd1_data_q   <= {DATA_W{1'b0}};
            rd1_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            clr_val_q    <= clr_val_d;
            auto_pend_q  <= auto_pend_d;
            busy_q       <= busy_d;
            clr_done_q   <= clr_done_d;
            rd1_data_q   <= rd1_data_d;
            rd1_valid_q  <= rd1_valid_d;
        end
    end

    assign busy     = busy_q;
    assign clr_done = clr_done_q;

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] rd2_data_q,  rd2_data_d;
        logic              rd2_valid_q, rd2_valid_d;

        // Second read stage: advances only when the first stage holds a completed read.
        always_comb begin
            if (rd1_valid_q) begin
                rd2_data_d = rd1_data_q;
            end else begin
                rd2_data_d = rd2_data_q;
            end
            rd2_valid_d = rd1_valid_q;
        end

        // Second read stage registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd2_data_q  <= {DATA_W{1'b0}};
                rd2_valid_q <= 1'b0;
            end else begin
                rd2_data_q  <= rd2_data_d;
                rd2_valid_q <= rd2_valid_d;
            end
        end

        assign rd_data  = rd2_data_q;
        assign rd_valid = rd2_valid_q;
    end else begin : g_no_out_reg
        assign rd_data  = rd1_data_q;
        assign rd_valid = rd1_valid_q;
    end

endmodule

// File: tb/tb_bram_sdp.sv
// Testbench for bram_sdp. Two instances share all inputs:
//   u0: OUT_REG=0, WR_FIRST=0, AUTO_CLEAR=0
//   u1: OUT_REG=1, WR_FIRST=1, AUTO_CLEAR=1
module tb_bram_sdp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_be;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        clr_req;
    logic [15:0] clr_data;

    logic [15:0] u0_rd_data, u1_rd_data;
    logic        u0_rd_valid, u1_rd_valid;
    logic        u0_busy, u1_busy;
    logic        u0_clr_done, u1_clr_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_sdp #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4), .OUT_REG(0), .WR_FIRST(0), .AUTO_CLEAR(0)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(u0_rd_data),
        .rd_valid(u0_rd_valid), .clr_req(clr_req), .clr_data(clr_data),
        .busy(u0_busy), .clr_done(u0_clr_done));

    bram_sdp #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4), .OUT_REG(1), .WR_FIRST(1), .AUTO_CLEAR(1)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(u1_rd_data),
        .rd_valid(u1_rd_valid), .clr_req(clr_req), .clr_data(clr_data),
        .busy(u1_busy), .clr_done(u1_clr_done));

    typedef struct {
        int          op;    // 0 write, 1 read, 2 same-cycle write+read
        logic [3:0]  addr;
        logic [1:0]  be;
        logic [15:0] data;
        logic [15:0] e0;    // expected read data, u0 (read-first)
        logic [15:0] e1;    // expected read data, u1 (write-first)
    } vec_t;

    vec_t        tbl [15];
    logic [15:0] tail [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Called at #1 after the edge that captured rd_en.
    task automatic read_tail(input logic [15:0] e0, input logic [15:0] e1, input bit c0, input bit c1);
        if (c0) begin
            check("u0_rd_valid_lat1", u0_rd_valid, 1);
            check("u0_rd_data", u0_rd_data, e0);
        end
        if (c1) check("u1_rd_valid_early", u1_rd_valid, 0);
        @(posedge clk); #1;
        if (c0) begin
            check("u0_rd_valid_drop", u0_rd_valid, 0);
            check("u0_rd_data_hold", u0_rd_data, e0);
        end
        if (c1) begin
            check("u1_rd_valid_lat2", u1_rd_valid, 1);
            check("u1_rd_data", u1_rd_data, e1);
        end
    endtask

    task automatic do_read(input logic [3:0] a, input logic [15:0] e0, input logic [15:0] e1,
                           input bit c0, input bit c1);
        rd_en = 1'b1; rd_addr = a;
        @(posedge clk); #1;
        rd_en = 1'b0;
        read_tail(e0, e1, c0, c1);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [1:0] be, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_collide(input logic [3:0] a, input logic [1:0] be, input logic [15:0] d,
                              input logic [15:0] e0, input logic [15:0] e1);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        rd_en = 1'b1; rd_addr = a;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        read_tail(e0, e1, 1'b1, 1'b1);
    endtask

    // Starts at #1 after the first edge of a sweep; counts busy cycles and done pulses.
    task automatic sweep_watch(input bit inject, output int nb0, output int nb1,
                               output int nd0, output int nd1);
        int it;
        it = 0; nb0 = 0; nb1 = 0; nd0 = 0; nd1 = 0;
        while ((u0_busy || u1_busy) && it < 40) begin
            if (u0_busy) nb0++;
            if (u1_busy) nb1++;
            if (inject && it == 4) begin
                wr_en = 1'b1; wr_addr = 4'd4; wr_be = 2'b11; wr_data = 16'h1234;
                clr_req = 1'b1; clr_data = 16'hAAAA;
            end else begin
                wr_en = 1'b0; clr_req = 1'b0;
            end
            it++;
            @(posedge clk); #1;
            if (u0_clr_done) nd0++;
            if (u1_clr_done) nd1++;
        end
        wr_en = 1'b0; clr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int nb0, nb1, nd0, nd1;

        tbl[0]  = '{0, 4'd3,  2'b11, 16'hA5C3, 16'h0000, 16'h0000};
        tbl[1]  = '{1, 4'd3,  2'b00, 16'h0000, 16'hA5C3, 16'hA5C3};
        tbl[2]  = '{0, 4'd5,  2'b11, 16'h1234, 16'h0000, 16'h0000};
        tbl[3]  = '{0, 4'd5,  2'b01, 16'hFFFF, 16'h0000, 16'h0000};
        tbl[4]  = '{1, 4'd5,  2'b00, 16'h0000, 16'h12FF, 16'h12FF};
        tbl[5]  = '{0, 4'd7,  2'b11, 16'h0001, 16'h0000, 16'h0000};
        tbl[6]  = '{2, 4'd7,  2'b11, 16'hBEEF, 16'h0001, 16'hBEEF};
        tbl[7]  = '{1, 4'd7,  2'b00, 16'h0000, 16'hBEEF, 16'hBEEF};
        tbl[8]  = '{0, 4'd9,  2'b10, 16'hABCD, 16'h0000, 16'h0000};
        tbl[9]  = '{1, 4'd9,  2'b00, 16'h0000, 16'hAB55, 16'hAB55};
        tbl[10] = '{0, 4'd10, 2'b00, 16'h1111, 16'h0000, 16'h0000};
        tbl[11] = '{1, 4'd10, 2'b00, 16'h0000, 16'h5555, 16'h5555};
        tbl[12] = '{2, 4'd11, 2'b01, 16'h0077, 16'h5555, 16'h5577};
        tbl[13] = '{1, 4'd11, 2'b00, 16'h0000, 16'h5577, 16'h5577};
        tbl[14] = '{1, 4'd15, 2'b00, 16'h0000, 16'h5555, 16'h5555};

        for (int i = 0; i < 16; i++) tail[i] = 16'h5555;
        tail[7]  = 16'hBEEF;
        tail[9]  = 16'hAB55;
        tail[11] = 16'h5577;

        rst_n = 1'b0; wr_en = 1'b0; wr_be = 2'b00; wr_addr = 4'd0; wr_data = 16'h0000;
        rd_en = 1'b0; rd_addr = 4'd0; clr_req = 1'b0; clr_data = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_u0_rd_data", u0_rd_data, 0);
        check("rst_u0_rd_valid", u0_rd_valid, 0);
        check("rst_u0_busy", u0_busy, 0);
        check("rst_u0_clr_done", u0_clr_done, 0);
        check("rst_u1_rd_data", u1_rd_data, 0);
        check("rst_u1_rd_valid", u1_rd_valid, 0);
        check("rst_u1_busy", u1_busy, 0);
        check("rst_u1_clr_done", u1_clr_done, 0);

        // Auto-clear on reset release (u1 only)
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("auto_u1_busy_rise", u1_busy, 1);
        check("auto_u0_stays_idle", u0_busy, 0);
        sweep_watch(1'b0, nb0, nb1, nd0, nd1);
        check("auto_u1_busy_cycles", nb1, 16);
        check("auto_u1_done_pulses", nd1, 1);
        check("auto_u0_busy_cycles", nb0, 0);
        check("auto_u0_done_pulses", nd0, 0);
        for (int i = 0; i < 16; i++) do_read(4'(i), 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Commanded clear with 0x5555, a lost write and an ignored clr_req in the middle
        clr_req = 1'b1; clr_data = 16'h5555;
        @(posedge clk); #1;
        clr_req = 1'b0;
        sweep_watch(1'b1, nb0, nb1, nd0, nd1);
        check("clr_u0_busy_cycles", nb0, 16);
        check("clr_u1_busy_cycles", nb1, 16);
        check("clr_u0_done_pulses", nd0, 1);
        check("clr_u1_done_pulses", nd1, 1);
        for (int i = 0; i < 16; i++) do_read(4'(i), 16'h5555, 16'h5555, 1'b1, 1'b1);

        // Table-driven write/read/collision vectors
        for (int i = 0; i < 15; i++) begin
            case (tbl[i].op)
                0: do_write(tbl[i].addr, tbl[i].be, tbl[i].data);
                1: do_read(tbl[i].addr, tbl[i].e0, tbl[i].e1, 1'b1, 1'b1);
                default: do_collide(tbl[i].addr, tbl[i].be, tbl[i].data, tbl[i].e0, tbl[i].e1);
            endcase
        end

        // Same-cycle clr_req + write: write lands, sweep starts next cycle; then abort by reset
        clr_req = 1'b1; clr_data = 16'h0F0F;
        wr_en = 1'b1; wr_addr = 4'd2; wr_be = 2'b11; wr_data = 16'hDEAD;
        @(posedge clk); #1;
        clr_req = 1'b0; wr_en = 1'b0;
        check("race_u0_busy", u0_busy, 1);
        check("race_u1_busy", u1_busy, 1);
        do_read(4'd2, 16'hDEAD, 16'hDEAD, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_u0_busy", u0_busy, 0);
        check("abort_u1_busy", u1_busy, 0);
        check("abort_u0_rd_data", u0_rd_data, 0);
        check("abort_u0_rd_valid", u0_rd_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rerelease_u0_idle", u0_busy, 0);
        check("rerelease_u1_auto", u1_busy, 1);
        for (int i = 0; i < 16; i++) begin
            if (i < 6) do_read(4'(i), 16'h0F0F, 16'h0000, 1'b1, 1'b0);
            else       do_read(4'(i), tail[i], 16'h0000, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
